// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared definitions for the exception/interrupt redirect sequencer:
// ExcCode values, default handler vector and the sequencer state encoding.
package exc_redirect_ctrl_pkg;

  // ExcCode values written into Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // General exception entry point (BEV=1)
  localparam logic [31:0] EXC_VEC_DEFAULT = 32'hBFC00380;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/exc_redirect_ctrl_oldest_sel.sv
// exc_oldest_sel: priority encoder returning the highest set request index
// (highest index = oldest pipeline stage) and whether any request is set.
module exc_oldest_sel #(
  parameter int NSTAGE = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NSTAGE-1:0] req,
  output logic [IDX_W-1:0]  sel,
  output logic              hit
);

  // later iterations overwrite earlier ones, so the highest index wins
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (req[i]) begin
        sel = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: picks the oldest excepting instruction (or a pending
// interrupt attached to the oldest stage), pulses a one-cycle commit to CP0,
// flushes the pipe for FLUSH_CYC cycles, then redirects fetch.
// Optional build macro EXC_REDIRECT_STATS_EN adds exc_count/int_count.
//
// Redirect handshake: redirect_valid rises with redirect_pc already stable;
// both hold unchanged until a cycle where redirect_valid & redirect_ready,
// after which redirect_valid drops on the next cycle. No new event is taken
// in that transfer cycle.
module exc_redirect_ctrl
  import exc_redirect_ctrl_pkg::*;
#(
  parameter int          NSTAGE    = 4,
  parameter int          FLUSH_CYC = 2,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSTAGE-1:0]    stg_valid,
  input  logic [NSTAGE-1:0]    stg_exc,
  input  logic [NSTAGE-1:0]    stg_eret,
  input  logic [NSTAGE-1:0]    stg_in_ds,
  input  logic [5*NSTAGE-1:0]  stg_code,
  input  logic [32*NSTAGE-1:0] stg_pc,
  input  logic [32*NSTAGE-1:0] stg_badvaddr,
  input  logic                 int_pending,
  input  logic [31:0]          cp0_epc,
  output logic                 commit_valid,
  output logic [4:0]           commit_code,
  output logic [31:0]          commit_pc,
  output logic [31:0]          commit_badvaddr,
  output logic                 commit_in_ds,
  output logic                 commit_eret,
  output logic [NSTAGE-1:0]    flush,
  output logic                 stall,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  input  logic                 redirect_ready,
  output logic [1:0]           dbg_state
`ifdef EXC_REDIRECT_STATS_EN
  ,
  output logic [31:0]          exc_count,
  output logic [31:0]          int_count
`endif
);

  localparam int IDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  state_t           state;
  logic [3:0]       flush_cnt;
  logic [IDX_W-1:0] oldest_idx;
  logic             exc_hit;
  logic             evt_take;
  logic [IDX_W-1:0] src_idx;
  logic [4:0]       evt_code;
  logic [31:0]      evt_pc;
  logic [31:0]      evt_badvaddr;
  logic             evt_in_ds;
  logic             evt_eret;

  assign dbg_state = state;

  exc_oldest_sel #(
    .NSTAGE(NSTAGE),
    .IDX_W (IDX_W)
  ) u_oldest_sel (
    .req(stg_valid & stg_exc),
    .sel(oldest_idx),
    .hit(exc_hit)
  );

  // choose the event source: oldest exception first, else interrupt on the oldest stage
  always_comb begin
    evt_take     = 1'b0;
    src_idx      = IDX_W'(NSTAGE - 1);
    evt_code     = EXC_INT;
    evt_pc       = '0;
    evt_badvaddr = '0;
    evt_in_ds    = 1'b0;
    evt_eret     = 1'b0;
    if (exc_hit) begin
      evt_take = 1'b1;
      src_idx  = oldest_idx;
    end else if (int_pending && stg_valid[NSTAGE-1]) begin
      evt_take = 1'b1;
    end
    for (int i = 0; i < NSTAGE; i++) begin
      if (IDX_W'(i) == src_idx) begin
        evt_pc       = stg_pc[i*32 +: 32];
        evt_badvaddr = stg_badvaddr[i*32 +: 32];
        evt_in_ds    = stg_in_ds[i];
        if (exc_hit) begin
          evt_code = stg_code[i*5 +: 5];
          evt_eret = stg_eret[i];
        end
      end
    end
  end

  // sequencer: IDLE -> FLUSH -> REDIRECT -> IDLE with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      flush_cnt       <= 4'd0;
      commit_valid    <= 1'b0;
      commit_code     <= 5'd0;
      commit_pc       <= 32'd0;
      commit_badvaddr <= 32'd0;
      commit_in_ds    <= 1'b0;
      commit_eret     <= 1'b0;
      flush           <= '0;
      stall           <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= 32'd0;
    end else begin
      commit_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (evt_take) begin
            commit_valid    <= 1'b1;
            commit_code     <= evt_code;
            commit_pc       <= evt_pc;
            commit_badvaddr <= evt_badvaddr;
            commit_in_ds    <= evt_in_ds;
            commit_eret     <= evt_eret;
            redirect_pc     <= evt_eret ? cp0_epc : EXC_VEC;
            flush_cnt       <= 4'(FLUSH_CYC - 1);
            flush           <= '1;
            stall           <= 1'b1;
            state           <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 4'd0) begin
            flush          <= '0;
            redirect_valid <= 1'b1;
            state          <= ST_REDIRECT;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            stall          <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: begin
          flush          <= '0;
          stall          <= 1'b0;
          redirect_valid <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef EXC_REDIRECT_STATS_EN
  // event counters, bumped on the same edge that raises commit_valid; ERET counts as an exception
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_count <= 32'd0;
      int_count <= 32'd0;
    end else if (state == ST_IDLE && evt_take) begin
      if (exc_hit) exc_count <= exc_count + 32'd1;
      else         int_count <= int_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Bench for exc_redirect_ctrl: directed events, a cycle-timeline reference
// model with a commit scoreboard, and literal checks on the directed cases.
module tb_exc_redirect_ctrl;
  import exc_redirect_ctrl_pkg::*;

  localparam int          N   = 4;
  localparam int          F   = 2;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          PW  = 71;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus arrays, packed onto the DUT buses ----------------
  logic        v_a[N], e_a[N], r_a[N], d_a[N];
  logic [4:0]  code_a[N];
  logic [31:0] pc_a[N], bva_a[N];

  logic [N-1:0]    stg_valid, stg_exc, stg_eret, stg_in_ds;
  logic [5*N-1:0]  stg_code;
  logic [32*N-1:0] stg_pc, stg_badvaddr;
  logic            int_pending, redirect_ready;
  logic [31:0]     cp0_epc;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      stg_valid[k]              = v_a[k];
      stg_exc[k]                = e_a[k];
      stg_eret[k]               = r_a[k];
      stg_in_ds[k]              = d_a[k];
      stg_code[k*5 +: 5]        = code_a[k];
      stg_pc[k*32 +: 32]        = pc_a[k];
      stg_badvaddr[k*32 +: 32]  = bva_a[k];
    end
  end

  logic          commit_valid, commit_in_ds, commit_eret;
  logic [4:0]    commit_code;
  logic [31:0]   commit_pc, commit_badvaddr, redirect_pc;
  logic [N-1:0]  flush;
  logic          stall, redirect_valid;
  logic [1:0]    dbg_state;
`ifdef EXC_REDIRECT_STATS_EN
  logic [31:0]   exc_count, int_count;
`endif

  exc_redirect_ctrl #(.NSTAGE(N), .FLUSH_CYC(F), .EXC_VEC(VEC)) dut (
    .clk(clk), .reset(reset),
    .stg_valid(stg_valid), .stg_exc(stg_exc), .stg_eret(stg_eret), .stg_in_ds(stg_in_ds),
    .stg_code(stg_code), .stg_pc(stg_pc), .stg_badvaddr(stg_badvaddr),
    .int_pending(int_pending), .cp0_epc(cp0_epc),
    .commit_valid(commit_valid), .commit_code(commit_code), .commit_pc(commit_pc),
    .commit_badvaddr(commit_badvaddr), .commit_in_ds(commit_in_ds), .commit_eret(commit_eret),
    .flush(flush), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .dbg_state(dbg_state)
`ifdef EXC_REDIRECT_STATS_EN
    , .exc_count(exc_count), .int_count(int_count)
`endif
  );

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks "cycles since the event was taken": age 1 is the commit
  // cycle, ages 1..F are flush cycles, ages above F are redirect cycles.
  logic [PW-1:0] exp_q[$];
  bit            m_live = 1'b0;
  bit            m_busy = 1'b0;
  int            m_age  = 0;
  logic [31:0]   m_rpc  = 32'd0;
  logic [31:0]   m_exc_n = 32'd0;
  logic [31:0]   m_int_n = 32'd0;

  always @(posedge clk) begin : model
    int pick;
    int s;
    bit is_exc;
    bit er;
    if (reset) begin
      m_live  = 1'b1;
      m_busy  = 1'b0;
      m_age   = 0;
      m_rpc   = 32'd0;
      m_exc_n = 32'd0;
      m_int_n = 32'd0;
      exp_q.delete();
    end else if (m_live) begin
      if (m_busy) begin
        if (m_age > F && redirect_ready) m_busy = 1'b0;
        else m_age++;
      end else begin
        pick = -1;
        for (int i = 0; i < N; i++) if (v_a[i] && e_a[i]) pick = i;
        if (pick >= 0 || (int_pending && v_a[N-1])) begin
          is_exc = (pick >= 0);
          s      = is_exc ? pick : N - 1;
          er     = is_exc && r_a[s];
          exp_q.push_back({er, d_a[s], is_exc ? code_a[s] : 5'd0, pc_a[s], bva_a[s]});
          m_rpc  = er ? cp0_epc : VEC;
          m_busy = 1'b1;
          m_age  = 1;
          if (is_exc) m_exc_n = m_exc_n + 32'd1;
          else        m_int_n = m_int_n + 32'd1;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin : compare
    logic [N-1:0] exp_flush;
    if (m_live) begin
      exp_flush = (m_busy && m_age <= F) ? {N{1'b1}} : {N{1'b0}};
      check("commit_valid", commit_valid, m_busy && m_age == 1);
      check("flush", flush, exp_flush);
      check("stall", stall, m_busy);
      check("redirect_valid", redirect_valid, m_busy && m_age > F);
      if (m_busy && m_age > F) check("redirect_pc", redirect_pc, m_rpc);
      if (commit_valid === 1'b1) begin
        check("commit_expected", exp_q.size(), 1);
        if (exp_q.size() != 0)
          check("commit_fields", {commit_eret, commit_in_ds, commit_code, commit_pc, commit_badvaddr},
                exp_q.pop_front());
      end
`ifdef EXC_REDIRECT_STATS_EN
      check("exc_count", exc_count, m_exc_n);
      check("int_count", int_count, m_int_n);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int k = 0; k < N; k++) begin
      v_a[k] = 1'b0; e_a[k] = 1'b0; r_a[k] = 1'b0; d_a[k] = 1'b0;
      code_a[k] = 5'd0; pc_a[k] = 32'd0; bva_a[k] = 32'd0;
    end
    int_pending = 1'b0;
    cp0_epc     = 32'd0;
  endtask

  task automatic set_stage(input int i, input bit exc, input bit eret, input bit ds,
                           input logic [4:0] code, input logic [31:0] pc, input logic [31:0] bva);
    v_a[i] = 1'b1; e_a[i] = exc; r_a[i] = eret; d_a[i] = ds;
    code_a[i] = code; pc_a[i] = pc; bva_a[i] = bva;
  endtask

  // Caller sets the stage inputs just after a rising edge; this holds them
  // for that cycle, then follows the event through flush and redirect.
  task automatic run_event(input string nm, output logic [PW-1:0] pkt,
                           output int nflush, output logic [31:0] rpc);
    int n;
    @(posedge clk); #1 clear_inputs();
    @(negedge clk);
    check({nm, "_commit_pulse"}, commit_valid, 1);
    pkt = {commit_eret, commit_in_ds, commit_code, commit_pc, commit_badvaddr};
    nflush = 0;
    while (flush === {N{1'b1}} && nflush < 20) begin
      nflush++;
      @(negedge clk);
    end
    check({nm, "_redirect_up"}, redirect_valid, 1);
    rpc = redirect_pc;
    n = 0;
    while ((stall !== 1'b0 || redirect_valid !== 1'b0) && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({nm, "_back_idle"}, {stall, redirect_valid}, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_redirect(input string nm);
    int n;
    n = 0;
    while (redirect_valid !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({nm, "_redirect_up"}, redirect_valid, 1);
  endtask

  // ---------------- directed sequence ----------------
  logic [PW-1:0] pkt;
  int            nfl;
  logic [31:0]   rpc;

  initial begin
    clear_inputs();
    redirect_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_commit_pc", commit_pc, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;

    // T2 single exception in stage 2 (Ov)
    set_stage(2, 1, 0, 0, EXC_OV, 32'h8000_1000, 32'h0);
    run_event("t2", pkt, nfl, rpc);
    check("t2_code", pkt[68:64], 5'h0C);
    check("t2_pc", pkt[63:32], 32'h8000_1000);
    check("t2_eret", pkt[70], 0);
    check("t2_flush_cycles", nfl, 2);
    check("t2_redirect_pc", rpc, 32'hBFC0_0380);

    // T3 oldest stage wins
    set_stage(1, 1, 0, 0, EXC_RI,   32'h8000_1100, 32'h0);
    set_stage(3, 1, 0, 0, EXC_ADEL, 32'h8000_1200, 32'h13);
    run_event("t3", pkt, nfl, rpc);
    check("t3_code", pkt[68:64], 5'h04);
    check("t3_badvaddr", pkt[31:0], 32'h13);
    check("t3_pc", pkt[63:32], 32'h8000_1200);

    // T4 ERET returns to EPC
    set_stage(3, 1, 1, 0, 5'h00, 32'h8000_3000, 32'h0);
    cp0_epc = 32'h8000_2000;
    run_event("t4", pkt, nfl, rpc);
    check("t4_eret", pkt[70], 1);
    check("t4_redirect_pc", rpc, 32'h8000_2000);

    // T5a interrupt alone attaches to the oldest stage (delay slot set)
    int_pending = 1'b1;
    set_stage(3, 0, 0, 1, 5'h1F, 32'h8000_0040, 32'h0);
    run_event("t5a", pkt, nfl, rpc);
    check("t5a_code", pkt[68:64], 5'h00);
    check("t5a_pc", pkt[63:32], 32'h8000_0040);
    check("t5a_in_ds", pkt[69], 1);
    check("t5a_redirect_pc", rpc, 32'hBFC0_0380);

    // T5b exception in a younger stage beats the interrupt
    int_pending = 1'b1;
    set_stage(3, 0, 0, 0, 5'h00,   32'h8000_0040, 32'h0);
    set_stage(0, 1, 0, 0, EXC_SYS, 32'h8000_0100, 32'h0);
    run_event("t5b", pkt, nfl, rpc);
    check("t5b_code", pkt[68:64], 5'h08);
    check("t5b_pc", pkt[63:32], 32'h8000_0100);

    // T6 backpressure, with new exceptions presented while busy
    redirect_ready = 1'b0;
    set_stage(2, 1, 0, 0, EXC_BP, 32'h8000_4000, 32'h0);
    @(posedge clk); #1 clear_inputs();
    set_stage(3, 1, 0, 0, EXC_SYS, 32'h8000_9000, 32'h0);
    @(negedge clk);
    wait_redirect("t6");
    for (int k = 0; k < 5; k++) begin
      check("t6_hold_valid", redirect_valid, 1);
      check("t6_hold_pc", redirect_pc, 32'hBFC0_0380);
      check("t6_hold_no_commit", commit_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1 redirect_ready = 1'b1;
    @(negedge clk);
    check("t6_xfer_valid", redirect_valid, 1);
    @(posedge clk); #1 clear_inputs();
    @(negedge clk);
    check("t6_exit_valid", redirect_valid, 0);
    check("t6_exit_stall", stall, 0);
    check("t6_exit_no_commit", commit_valid, 0);
    repeat (3) @(negedge clk);

    // T1 reset held 3 cycles in the middle of REDIRECT
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    set_stage(1, 1, 0, 0, EXC_ADES, 32'h8000_5000, 32'h44);
    @(posedge clk); #1 clear_inputs();
    @(negedge clk);
    wait_redirect("t1");
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t1_commit_valid", commit_valid, 0);
    check("t1_redirect_valid", redirect_valid, 0);
    check("t1_flush", flush, 0);
    check("t1_stall", stall, 0);
    check("t1_state", dbg_state, 0);
    redirect_ready = 1'b1;

    // recovery after reset
    @(posedge clk); #1;
    set_stage(3, 1, 0, 0, EXC_OV, 32'h8000_6000, 32'h0);
    run_event("post", pkt, nfl, rpc);
    check("post_code", pkt[68:64], 5'h0C);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // overall time limit
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
